fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set instruction queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h00000000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ack  input  1  read data valid; meaningful only while imem_req=1.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_req&&imem_ack.
REQ-009 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch target.
REQ-011 inst_valid  output  1  queue head holds a valid instruction for decode.
REQ-012 inst_data  output  32  instruction word at queue head.
REQ-013 inst_pc  output  32  address of inst_data.
REQ-014 inst_ready  input  1  decode consumes head when inst_valid&&inst_ready.

Function
REQ-015 At most one imem request SHALL be outstanding; once raised, imem_req and imem_addr SHALL hold stable until the cycle imem_req&&imem_ack.
REQ-016 A new request SHALL be issued only when (queue count + outstanding) < DEPTH, so the queue never overflows.
REQ-017 On imem_req&&imem_ack in state FETCH, {imem_rdata, imem_addr} SHALL be pushed; inst_valid SHALL rise the next cycle (1-cycle ack-to-decode latency); fetch_pc SHALL advance by 4.
REQ-018 fetch_pc SHALL wrap 32'hFFFFFFFC -> 32'h00000000 without error.
REQ-019 State machine: IDLE (no request), FETCH (request outstanding), DROP (outstanding request to be discarded); IDLE->FETCH on issue condition; FETCH->IDLE on ack if issue condition false, else FETCH with next address the following cycle (back-to-back requests allowed); DROP->FETCH on ack.
REQ-020 redirect_valid SHALL flush the queue (inst_valid=0 next cycle), load fetch_pc with {redirect_pc[31:2],2'b00}; if a request is outstanding and not acked that cycle, go to DROP.
REQ-021 In DROP, imem_req/imem_addr SHALL hold the stale request; its returned data SHALL be discarded; the redirect target is requested the cycle after ack.
REQ-022 redirect_valid coincident with ack SHALL win: returned data discarded, no DROP, redirect target requested next cycle.
REQ-023 redirect_valid coincident with a decode pop SHALL flush; the pop has no further effect.
REQ-024 Simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-025 When inst_valid=0, inst_data SHALL read 32'h00000013 (NOP) and inst_pc 0.

Reset
REQ-026 While reset=1: imem_req=0, imem_addr=RESET_PC, state IDLE, queue empty, inst_valid=0, inst_data=NOP, inst_pc=0, counters 0.
REQ-027 First request (address RESET_PC) SHALL assert the first cycle after reset deasserts; reset mid-request SHALL abandon it without a DROP.

Configuration
REQ-028 Macro FETCH_PERF_EN defined: outputs perf_fetch_cnt (32, pushes accepted) and perf_flush_cnt (32, redirects) SHALL exist, wrapping at 2^32; undefined: ports and counters SHALL be absent, function otherwise identical.

Structure
REQ-029 Package fetch_pkg SHALL hold the state enum, INST_NOP constant and default RESET_PC.
REQ-030 Queue SHALL be sub-module fetch_fifo (DEPTH, 64-bit entries, push/pop/flush, count output).

Verification
REQ-031 Reset release, imem_ack tied 1, inst_ready=1 -> addresses 0,4,8,... issued back-to-back; inst_pc follows one cycle after each ack.
REQ-032 inst_ready=0, ack always 1, DEPTH=4 -> exactly 4 pushes, imem_req stays 0 afterwards; inst_ready=1 -> fetch resumes at 0x10.
REQ-033 Request to 0x8 outstanding, redirect to 0x103 with ack 3 cycles later -> imem_addr holds 0x8 until ack, data dropped, next request 0x100, first inst_pc 0x100.
REQ-034 Redirect to 0x40 on the same cycle as ack of 0x8 -> 0x8 never appears at inst_pc; next request 0x40.
REQ-035 RESET_PC=32'hFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-036 FETCH_PERF_EN, 10 accepted fetches and 2 redirects -> perf_fetch_cnt=10, perf_flush_cnt=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t    : request state machine encoding
//   INST_NOP         : word presented to decode when the queue is empty
//   DEFAULT_RESET_PC : default first fetch address after reset
//   align_pc()       : clears the byte-offset bits of an address
package fetch_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StDrop
   } fetch_state_t;

   localparam logic [31:0] INST_NOP         = 32'h00000013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue holding {instruction, pc} pairs for decode.
//   clk, reset : clock and synchronous active-high reset
//   push/wdata : write one 64-bit entry at the tail
//   pop        : discard the head entry
//   flush      : empty the queue (takes priority over push/pop)
//   rdata      : head entry (undefined while count == 0)
//   count      : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [63:0]            wdata,
   output logic [63:0]            rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem[rptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory, queues
// returned words with their addresses and hands them to decode. Redirects
// flush the queue; a request still in flight at redirect time is completed
// and its data discarded.
//   clk, reset                : clock and synchronous active-high reset
//   imem_req/imem_addr        : fetch request, held stable until acked
//   imem_ack/imem_rdata       : memory response
//   redirect_valid/_pc        : taken branch / jump target
//   inst_valid/data/pc, ready : decode handshake at the queue head
//   perf_fetch_cnt/flush_cnt  : present only when FETCH_PERF_EN is defined
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_t  state;
   logic [31:0]   fetch_pc;   // address of the next request to issue
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [63:0]   head;
   logic [31:0]   target;
   logic          acked;
   logic          push;
   logic          pop;
   logic          room;
   logic          busy_after;

   always_comb begin
      acked      = imem_req && imem_ack;
      push       = (state == StFetch) && acked && !redirect_valid;
      pop        = inst_valid && inst_ready && !redirect_valid;
      count_nxt  = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
      // A new request may go out only if its data is guaranteed a slot.
      room       = count_nxt < CW'(DEPTH);
      busy_after = (state != StIdle) && !acked;
      target     = redirect_valid ? align_pc(redirect_pc) : fetch_pc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         fetch_pc  <= RESET_PC;
      end else if (busy_after) begin
         // Request still in flight: hold it; a redirect turns it stale.
         fetch_pc <= target;
         if (redirect_valid) state <= StDrop;
      end else if (room) begin
         state     <= StFetch;
         imem_req  <= 1'b1;
         imem_addr <= target;
         fetch_pc  <= target + 32'd4;
      end else begin
         state    <= StIdle;
         imem_req <= 1'b0;
         fetch_pc <= target;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata ({imem_rdata, imem_addr}),
      .rdata (head),
      .count (count)
   );

   assign inst_valid = (count != '0);
   assign inst_data  = inst_valid ? head[63:32] : INST_NOP;
   assign inst_pc    = inst_valid ? head[31:0]  : 32'h0;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (push)           perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A second instance with RESET_PC near the
// top of the address space shares all inputs to exercise pc wrap-around.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_ack;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_ready;

   logic        imem_req,   imem_req2;
   logic [31:0] imem_addr,  imem_addr2;
   logic [31:0] imem_rdata, imem_rdata2;
   logic        inst_valid, inst_valid2;
   logic [31:0] inst_data,  inst_data2;
   logic [31:0] inst_pc,    inst_pc2;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt,  perf_flush_cnt;
   logic [31:0] perf_fetch_cnt2, perf_flush_cnt2;
`endif

   localparam logic [31:0] TAG = 32'h5A5A0000;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Memory model: each word is its address xor a fixed tag.
   assign imem_rdata  = imem_addr  ^ TAG;
   assign imem_rdata2 = imem_addr2 ^ TAG;

   fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (32'h00000000)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (32'hFFFFFFF8)
   ) dut2 (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req2),
      .imem_addr      (imem_addr2),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata2),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid2),
      .inst_data      (inst_data2),
      .inst_pc        (inst_pc2),
      .inst_ready     (inst_ready)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt2),
      .perf_flush_cnt (perf_flush_cnt2)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      reset          = 1'b1;
      imem_ack       = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      tick();
      tick();

      // Reset state
      check("rst_req",   32'(imem_req),   32'd0);
      check("rst_addr",  imem_addr,       32'h0);
      check("rst_addr2", imem_addr2,      32'hFFFFFFF8);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_data",  inst_data,       32'h00000013);
      check("rst_pc",    inst_pc,         32'h0);

      // Streaming with ack tied high: back-to-back requests, pc wraps on dut2
      imem_ack   = 1'b1;
      inst_ready = 1'b1;
      reset      = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check("a_req",   32'(imem_req), 32'd1);
         check("a_addr",  imem_addr,  32'(4 * (k - 1)));
         check("a_addr2", imem_addr2, 32'hFFFFFFF8 + 32'(4 * (k - 1)));
         if (k >= 2) begin
            check("a_valid", 32'(inst_valid), 32'd1);
            check("a_pc",    inst_pc,   32'(4 * (k - 2)));
            check("a_data",  inst_data, 32'(4 * (k - 2)) ^ TAG);
            check("a_pc2",   inst_pc2,  32'hFFFFFFF8 + 32'(4 * (k - 2)));
         end else begin
            check("a_valid0", 32'(inst_valid), 32'd0);
         end
      end

      // Reset in the middle of a request abandons it
      do_reset();
      check("mid_rst_req",   32'(imem_req),   32'd0);
      check("mid_rst_addr",  imem_addr,       32'h0);
      check("mid_rst_valid", 32'(inst_valid), 32'd0);

      // Decode stalled: queue fills with exactly DEPTH entries
      reset      = 1'b0;
      inst_ready = 1'b0;
      imem_ack   = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("b_req",  32'(imem_req), 32'd1);
         check("b_addr", imem_addr, 32'(4 * (k - 1)));
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         check("b_full_req", 32'(imem_req), 32'd0);
         check("b_head_pc",  inst_pc, 32'h0);
      end
      inst_ready = 1'b1;
      tick();
      check("b_resume_req",  32'(imem_req), 32'd1);
      check("b_resume_addr", imem_addr, 32'h10);
      check("b_resume_pc",   inst_pc,   32'h4);

      // Redirect with the request to 0x8 still outstanding
      do_reset();
      reset      = 1'b0;
      imem_ack   = 1'b0;
      inst_ready = 1'b1;
      tick();
      check("c_addr0", imem_addr, 32'h0);
      imem_ack = 1'b1;
      tick();
      tick();
      check("c_addr8", imem_addr, 32'h8);
      imem_ack       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      tick();
      redirect_valid = 1'b0;
      check("c_drop_req",   32'(imem_req),   32'd1);
      check("c_drop_addr",  imem_addr,       32'h8);
      check("c_flush",      32'(inst_valid), 32'd0);
      check("c_flush_data", inst_data,       32'h00000013);
      tick();
      check("c_hold1", imem_addr, 32'h8);
      tick();
      check("c_hold2", imem_addr, 32'h8);
      imem_ack = 1'b1;
      tick();
      check("c_new_addr", imem_addr,       32'h100);
      check("c_dropped",  32'(inst_valid), 32'd0);
      tick();
      check("c_valid",  32'(inst_valid), 32'd1);
      check("c_pc",     inst_pc,   32'h100);
      check("c_data",   inst_data, 32'h100 ^ TAG);
      check("c_next",   imem_addr, 32'h104);

      // Redirect coincident with the ack of 0x8 (and with a decode pop)
      do_reset();
      reset      = 1'b0;
      imem_ack   = 1'b1;
      inst_ready = 1'b1;
      tick();
      tick();
      tick();
      check("d_addr8", imem_addr, 32'h8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      tick();
      redirect_valid = 1'b0;
      check("d_addr",  imem_addr,       32'h40);
      check("d_flush", 32'(inst_valid), 32'd0);
      tick();
      check("d_valid", 32'(inst_valid), 32'd1);
      check("d_pc",    inst_pc,   32'h40);
      check("d_next",  imem_addr, 32'h44);

      // Ten accepted fetches then two redirects with no ack
      do_reset();
      reset      = 1'b0;
      imem_ack   = 1'b1;
      inst_ready = 1'b1;
      for (int k = 0; k < 11; k++) tick();
      check("f_addr", imem_addr, 32'h28);
      imem_ack       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      tick();
      redirect_valid = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      tick();
      redirect_valid = 1'b0;
      tick();
      check("f_drop_addr", imem_addr,       32'h28);
      check("f_drop_req",  32'(imem_req),   32'd1);
      check("f_flushed",   32'(inst_valid), 32'd0);
`ifdef FETCH_PERF_EN
      check("f_perf_fetch", perf_fetch_cnt, 32'd10);
      check("f_perf_flush", perf_flush_cnt, 32'd2);
`endif
      imem_ack = 1'b1;
      tick();
      check("f_target", imem_addr, 32'h300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
